// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared definitions for the data memory responder:
//   - funct3 size codes (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU)
//   - FSM state encoding (ST_IDLE, ST_WAIT, ST_ACCESS, ST_DONE)
//   - mem_req_t : request fields latched in IDLE
//   - mem_fault() : access fault check applied in ACCESS
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef struct packed {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
    } mem_req_t;

    // offset is the byte address relative to the RAM base; the range test is an
    // unsigned compare so addresses below the base wrap to large offsets and fault.
    function automatic logic mem_fault(
        input logic        we,
        input logic [2:0]  size,
        input logic [1:0]  addr_lo,
        input logic [31:0] offset,
        input logic [31:0] span_bytes,
        input logic        trap_en
    );
        logic bad_size;
        logic bad_store;
        logic out_of_range;
        logic misaligned;
        bad_size     = (size == 3'd3) || (size == 3'd6) || (size == 3'd7);
        bad_store    = we && ((size == SZ_BU) || (size == SZ_HU));
        out_of_range = (offset >= span_bytes);
        misaligned   = trap_en &&
                       ((((size == SZ_H) || (size == SZ_HU)) && addr_lo[0]) ||
                        ((size == SZ_W) && (addr_lo != 2'b00)));
        return bad_size || bad_store || out_of_range || misaligned;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
// CPU data-port bus between the CPU (master) and the memory responder (slave).
//   REQ   : access request, held stable while STALL=1
//   WE    : 1 = store, 0 = load
//   SIZE  : funct3 size code
//   ADDR  : byte address
//   WD    : store data, right-aligned
//   RD    : load data, right-aligned and extended (registered)
//   STALL : CPU must hold the current instruction
//   ERROR : access fault, valid in the DONE cycle only
// -----------------------------------------------------------------------------
interface data_mem_responder_if;
    logic        REQ;
    logic        WE;
    logic [2:0]  SIZE;
    logic [31:0] ADDR;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        STALL;
    logic        ERROR;

    modport master (output REQ, WE, SIZE, ADDR, WD, input  RD, STALL, ERROR);
    modport slave  (input  REQ, WE, SIZE, ADDR, WD, output RD, STALL, ERROR);
endinterface

// File: rtl/data_mem_responder_mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane steering for the data memory.
//   size        : funct3 size code
//   addr_lo     : ADDR[1:0] of the access
//   wd          : right-aligned store data
//   rdata_word  : full RAM word being read
//   be          : per-byte write enables
//   wdata_lanes : store data replicated into its target lanes
//   rdata_ext   : selected lane(s) shifted to bit 0 and sign/zero-extended
// Halfword and word accesses ignore the low address bits they cannot use,
// which is what aligns misaligned accesses down when trapping is disabled.
// -----------------------------------------------------------------------------
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wd,
    input  logic [31:0] rdata_word,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext
);

    logic is_byte;
    logic is_half;
    logic [1:0]  lane_sel;
    logic [31:0] shifted;

    assign is_byte = (size == SZ_B) || (size == SZ_BU);
    assign is_half = (size == SZ_H) || (size == SZ_HU);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign be[gi] = is_byte ? (addr_lo == LANE) :
                        is_half ? (addr_lo[1] == LANE[1]) : 1'b1;
        assign wdata_lanes[gi*8 +: 8] = is_byte ? wd[7:0] :
                                        is_half ? wd[(gi%2)*8 +: 8] :
                                                  wd[gi*8 +: 8];
    end

    assign lane_sel = is_byte ? addr_lo :
                      is_half ? {addr_lo[1], 1'b0} : 2'b00;
    assign shifted  = rdata_word >> {lane_sel, 3'b000};

    always_comb begin
        rdata_ext = shifted;
        case (size)
            SZ_B:    rdata_ext = {{24{shifted[7]}},  shifted[7:0]};
            SZ_BU:   rdata_ext = {24'd0,             shifted[7:0]};
            SZ_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            SZ_HU:   rdata_ext = {16'd0,             shifted[15:0]};
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the CPU data port. Latches a load/store request in
// IDLE, waits WAIT_STATES cycles, performs the access on an internal word RAM
// in ACCESS and releases the CPU in DONE.
// Parameters:
//   DEPTH_WORDS : RAM depth in 32-bit words (power of two, >= 4)
//   WAIT_STATES : extra stall cycles per access (0..15)
//   BASE_ADDR   : byte address of RAM word 0
// Ports:
//   CLK   : clock, rising edge
//   RESET : synchronous active-low reset
//   bus   : data_mem_responder_if.slave (REQ/WE/SIZE/ADDR/WD in, RD/STALL/ERROR out)
// Build option:
//   MEM_MISALIGN_TRAP_EN : when defined, misaligned H/HU/W accesses fault;
//                          otherwise they are aligned down and complete.
// -----------------------------------------------------------------------------
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    data_mem_responder_if.slave  bus
);

    localparam int          AW         = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);
`ifdef MEM_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    logic [1:0]  state_reg;
    logic [3:0]  cnt_reg;
    mem_req_t    req_reg;
    logic [31:0] rd_reg;
    logic        err_reg;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic          fault;
    logic          wr_en;
    logic [3:0]    be;
    logic [31:0]   wdata_lanes;
    logic [31:0]   rdata_word;
    logic [31:0]   rdata_ext;

    assign offset   = req_reg.addr - BASE_ADDR;
    assign word_idx = offset[AW+1:2];
    assign fault    = mem_fault(req_reg.we, req_reg.size, req_reg.addr[1:0],
                                offset, SPAN_BYTES, TRAP_EN);
    // Reset wins over a write landing on the same edge.
    assign wr_en    = RESET && (state_reg == ST_ACCESS) && req_reg.we && !fault;

    assign rdata_word = mem[word_idx];

    mem_lane_align u_lane_align (
        .size        (req_reg.size),
        .addr_lo     (req_reg.addr[1:0]),
        .wd          (req_reg.wd),
        .rdata_word  (rdata_word),
        .be          (be),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext)
    );

    // RAM contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][i*8 +: 8] <= wdata_lanes[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            req_reg   <= '0;
            rd_reg    <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.REQ) begin
                        req_reg.we   <= bus.WE;
                        req_reg.size <= bus.SIZE;
                        req_reg.addr <= bus.ADDR;
                        req_reg.wd   <= bus.WD;
                        cnt_reg      <= 4'(WAIT_STATES);
                        state_reg    <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    err_reg <= fault;
                    if (fault) begin
                        rd_reg <= 32'd0;
                    end else if (!req_reg.we) begin
                        rd_reg <= rdata_ext;
                    end
                    state_reg <= ST_DONE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // In IDLE the stall follows REQ combinationally so the CPU freezes in the
    // same cycle it issues the access.
    assign bus.STALL = RESET && ((state_reg == ST_IDLE) ? bus.REQ
                                                        : (state_reg != ST_DONE));
    assign bus.ERROR = (state_reg == ST_DONE) && err_reg;
    assign bus.RD    = rd_reg;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the CPU data port. It accepts a load or store request carrying address, size code, write enable and write data. It executes the request against an internal word-organized RAM with a configurable number of wait states, then returns size-extended read data. The CPU is held with STALL until the access completes. It sits between riscv_cpu's MemReq/MemWE/MemSize/MemA/MemWD outputs and its MemRD input, replacing the zero-latency DataMemory.

## Interface
- DEPTH_WORDS, 256: RAM depth in 32-bit words; power of two, at least 4.
- WAIT_STATES, 1: extra stall cycles per access; range 0..15.
- BASE_ADDR, 32'h0: byte address of RAM word 0.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- REQ  in  1  access request; held stable by the CPU while STALL=1.
- WE  in  1  1 = store, 0 = load.
- SIZE  in  3  funct3 size code: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
- ADDR  in  32  byte address.
- WD  in  32  store data, right-aligned.
- RD  out  32  load data, right-aligned and extended; registered.
- STALL  out  1  CPU must hold the current instruction.
- ERROR  out  1  access fault; valid in the DONE cycle only.

## Operation
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - If REQ=1, latch ADDR/SIZE/WE/WD and load cnt=WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, otherwise ACCESS.
  - STALL=REQ.
- WAIT: cnt decrements each cycle; at cnt=1 go to ACCESS. STALL=1.
- ACCESS:
  - Run the fault check (below) on the latched request.
  - No fault, store: write byte lanes per SIZE and ADDR[1:0]. B writes one lane, H writes lanes {1:0} or {3:2}, W writes all four. Other lanes are unchanged.
  - No fault, load: read the word, shift the selected lane to bit 0, then sign-extend (B/H) or zero-extend (BU/HU). Register the result into RD.
  - Fault: no RAM write, RD=0, error flag set.
  - Next state DONE. STALL=1.
- DONE: STALL=0, ERROR=flag. The CPU retires the instruction at this edge. Next state IDLE.
- Fault conditions:
  - SIZE is 3, 6 or 7.
  - WE=1 with SIZE 4 or 5.
  - (ADDR-BASE_ADDR) ≥ 4·DEPTH_WORDS, using unsigned 32-bit compare with wrap-around.
  - Misalignment, as set by the configuration macro.
- RD holds its value until the next load completes. Stores do not change RD.

## Timing
- Reset values: state=IDLE, RD=0, ERROR=0, cnt=0. STALL is forced to 0 while RESET=0. RAM contents are not cleared.
- Request latency: IDLE, then WAIT×WAIT_STATES, then ACCESS, all with STALL=1. DONE follows with STALL=0. Total is WAIT_STATES+3 cycles, and the request retires at the end of the DONE cycle.
- Back-to-back requests: the next request is accepted in the IDLE cycle right after DONE. There are no dead cycles beyond IDLE.
- Inputs are sampled only in IDLE. Input changes during WAIT or ACCESS are ignored.
- REQ=0 in IDLE: STALL=0 and there is no state change.
- RESET low mid-access: return to IDLE on the next edge. A store still in WAIT is dropped. A store already written in ACCESS is kept.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Fault if H/HU has ADDR[0]=1, or if W has ADDR[1:0]≠0.
  - A faulted store writes nothing.
- MEM_MISALIGN_TRAP_EN undefined:
  - The address is aligned down: H/HU clears ADDR[0], W clears ADDR[1:0].
  - The access completes with ERROR=0.

## Structure
- Shared package holds:
  - size-code localparams SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU;
  - the FSM state encoding;
  - the mem_fault check as a function.
- One sub-module, mem_lane_align. It is combinational and produces byte enables, the shifted store word, and the extracted and extended load word from SIZE, ADDR[1:0] and the data.
- RAM is an inferred register array with per-byte write enables.

## Test plan
- WAIT_STATES=1: SW 32'hDEADBEEF to 0x10, then LW from 0x10. Expect RD=32'hDEADBEEF. STALL is high for exactly 3 cycles per access and ERROR=0.
- After that word: LB from 0x13 gives 32'hFFFFFFDE, LBU from 0x13 gives 32'h000000DE, LH from 0x10 gives 32'hFFFFBEEF, LHU from 0x12 gives 32'h0000DEAD.
- SB 8'h55 to 0x11, then LW from 0x10. Expect 32'hDEAD55EF: the other lanes are untouched.
- LW from 0x12:
  - With MEM_MISALIGN_TRAP_EN: ERROR=1 in DONE and RD=0.
  - Without it: RD equals the word at 0x10 and ERROR=0.
- SW to 4·DEPTH_WORDS: ERROR=1, and a following LW from 0x0 returns the previously written value unchanged. SIZE=3 load: ERROR=1.
- Start an SW of 32'h1 to 0x20 with WAIT_STATES=4, then pull RESET low during WAIT. The state goes to IDLE, STALL=0 and RD=0. A later LW from 0x20 returns the old contents.
